// File: rtl/gen_tick_pkg.sv
// gen_tick_pkg: shared constants, default-rate helpers and channel state encoding for gen_tick_multi
package gen_tick_pkg;

    localparam int CH_IDX_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} ch_state_t;

    function automatic int def_period(input int src_freq, input int tick_freq);
        return (tick_freq == 0) ? 0 : src_freq / tick_freq;
    endfunction

    function automatic int def_high(input int src_freq, input int tick_freq);
        return def_period(src_freq, tick_freq) / 2;
    endfunction

endpackage

// File: rtl/gen_tick_ch.sv
// gen_tick_ch: one programmable tick channel with shadowed config committed on period boundaries
module gen_tick_ch
    import gen_tick_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int BURST_W   = 8,
    parameter int SRC_FREQ  = 100,
    parameter int TICK_FREQ = 2
) (
    input  logic               src_clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               wr,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic               pending,
    output logic               tick,
    output logic               pulse,
    output logic               done
);

    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(def_period(SRC_FREQ, TICK_FREQ));
    localparam logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(def_high(SRC_FREQ, TICK_FREQ));

    logic [CNT_W-1:0]   cnt, period, high, sh_period, sh_high;
    logic [BURST_W-1:0] burst_cnt, burst, sh_burst;
    logic               en_d, en_rise, running, wrap, last, commit;
    ch_state_t          state;

    // A rising en revives a finished burst in the same edge, so restart has no extra latency
    always_comb begin
        en_rise = en & ~en_d;
        state   = (done && !en_rise) ? DONE : (en && period != '0) ? RUN : IDLE;
        running = state == RUN;
        wrap    = running && cnt == period - CNT_W'(1);
        last    = wrap && burst != '0 && burst_cnt == burst - BURST_W'(1);
        commit  = pending && (!running || wrap);
    end

    always_ff @(posedge src_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            burst_cnt <= '0;
            tick      <= 1'b0;
            pulse     <= 1'b0;
            done      <= 1'b0;
            pending   <= 1'b0;
            en_d      <= 1'b0;
            period    <= DEF_PERIOD;
            high      <= DEF_HIGH;
            burst     <= '0;
            sh_period <= DEF_PERIOD;
            sh_high   <= DEF_HIGH;
            sh_burst  <= '0;
        end else begin
            en_d <= en;
            if (!running) begin
                cnt       <= '0;
                burst_cnt <= '0;
                tick      <= 1'b0;
                pulse     <= 1'b0;
            end else begin
                cnt       <= wrap ? '0 : cnt + CNT_W'(1);
                burst_cnt <= last ? '0 : wrap ? burst_cnt + BURST_W'(1) : burst_cnt;
                tick      <= !last && cnt < high;
                pulse     <= cnt == '0 && high != '0;
            end
            // Commit lands on the wrap edge so the next period starts cleanly with the new values
            if (commit) begin
                period    <= sh_period;
                high      <= sh_high;
                burst     <= sh_burst;
                burst_cnt <= '0;
                pending   <= 1'b0;
            end else if (wr) begin
                sh_period <= cfg_period;
                sh_high   <= cfg_high;
                sh_burst  <= cfg_burst;
                pending   <= 1'b1;
            end
            done <= (commit || en_rise) ? 1'b0 : last ? 1'b1 : done;
        end
    end

endmodule

// File: rtl/gen_tick_multi.sv
// gen_tick_multi: NUM_CH independent runtime-programmable tick generators behind one config port
module gen_tick_multi
    import gen_tick_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int BURST_W   = 8,
    parameter int SRC_FREQ  = 100,
    parameter int TICK_FREQ = 2
) (
    input  logic                src_clk,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [BURST_W-1:0]  cfg_burst,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   pulse,
    output logic [NUM_CH-1:0]   done
);

    localparam int SLOTS = 2 ** CH_IDX_W;

    logic [NUM_CH-1:0] pending;
    logic [SLOTS-1:0]  pending_all;

    // Unpopulated channel slots read as never pending, so writes to them are accepted and dropped
    assign pending_all = SLOTS'(pending);
    assign cfg_ready   = !pending_all[cfg_ch];

    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        gen_tick_ch #(
            .CNT_W    (CNT_W),
            .BURST_W  (BURST_W),
            .SRC_FREQ (SRC_FREQ),
            .TICK_FREQ(TICK_FREQ)
        ) u_ch (
            .src_clk   (src_clk),
            .reset_n   (reset_n),
            .en        (en[i]),
            .wr        (cfg_valid && cfg_ready && cfg_ch == CH_IDX_W'(i)),
            .cfg_period(cfg_period),
            .cfg_high  (cfg_high),
            .cfg_burst (cfg_burst),
            .pending   (pending[i]),
            .tick      (tick[i]),
            .pulse     (pulse[i]),
            .done      (done[i])
        );
    end

endmodule
